board_scanner: RTL and testbench

//  Raster-scans the game board cell store and streams every cell out as (x, y, value) over a valid/ready

---
 rtl/board_pkg.sv | 34 +++
 rtl/board_scanner_if.sv | 42 ++++
 rtl/board_cursor.sv | 54 +++++
 rtl/board_scanner.sv | 163 ++++++++++++++++
 tb/tb_board_scanner.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the game-board blocks (board store, scanner, renderer).
//   DEFAULT_BUS_WIDTH : default number of bits per board cell value
//   scan_state_t      : raster-scan FSM states
//   clog2()           : index width needed to address n items (minimum 1 bit)
// -----------------------------------------------------------------------------
package board_pkg;

  localparam int DEFAULT_BUS_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PRESENT,
    DONE
  } scan_state_t;

  // Evaluated at elaboration time to size the x/y counters. It never returns
  // 0, so even a degenerate dimension still gets a real 1-bit index.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/board_scanner_if.sv
// -----------------------------------------------------------------------------
// board_scanner_if
// Cell stream produced by the board scanner and consumed by the renderer or
// the game logic.
//   out_valid  : a cell is being presented
//   out_ready  : the consumer accepts the cell (valid & ready at posedge clk)
//   out_x/out_y: board coordinates of the presented cell
//   out_value  : cell contents
//   out_first  : the presented cell is (0,0)
//   out_last   : the presented cell is (WIDTH-1,HEIGHT-1)
// Modports: master (scanner side), slave (consumer side).
// -----------------------------------------------------------------------------
interface board_scanner_if
  import board_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
);

  localparam int XW = clog2(WIDTH);
  localparam int YW = clog2(HEIGHT);

  logic                 out_valid;
  logic                 out_ready;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;
  logic [BUS_WIDTH-1:0] out_value;
  logic                 out_first;
  logic                 out_last;

  modport master (
    output out_valid, out_x, out_y, out_value, out_first, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_value, out_first, out_last,
    output out_ready
  );

endinterface

// File: rtl/board_cursor.sv
// -----------------------------------------------------------------------------
// board_cursor
// Row-major x/y position counter over a WIDTH x HEIGHT board.
//   clk, reset : clock, asynchronous active-low reset (cursor returns to (0,0))
//   clear      : synchronous return to (0,0); has priority over advance
//   advance    : step to the next cell (x first, then wrap into the next row)
//   x, y       : current position
//   is_first   : current position is (0,0)
//   is_last    : current position is (WIDTH-1,HEIGHT-1)
// -----------------------------------------------------------------------------
module board_cursor
  import board_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int HEIGHT = 16,
  localparam int XW     = clog2(WIDTH),
  localparam int YW     = clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          is_first,
  output logic          is_last
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  // The last cell is sticky: advancing from it does nothing, so the cursor
  // can never wrap back to (0,0) without an explicit clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !is_last) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign is_first = (x == '0) && (y == '0);
  assign is_last  = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/board_scanner.sv
// -----------------------------------------------------------------------------
// board_scanner
// Raster-scans the board cell store once per start pulse and streams every
// cell out as (x, y, value) in row-major order.
//   clk, reset    : clock, asynchronous active-low reset
//   start         : begin a frame (only looked at while idle)
//   abort         : synchronous abort back to idle, no frame_done
//   busy          : high whenever not idle
//   rd_en/rd_x/rd_y : board store read port; rd_value returns one cycle later
//   scan_out      : cell stream (board_scanner_if.master)
//   frame_done    : one-cycle pulse after the final cell is accepted/skipped
// Build option: define BOARD_SCAN_SKIP_EMPTY_EN to drop zero-valued cells
// from the stream instead of presenting them.
// -----------------------------------------------------------------------------
module board_scanner
  import board_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int HEIGHT    = 16,
  parameter  int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  localparam int XW        = clog2(WIDTH),
  localparam int YW        = clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 rd_en,
  output logic [XW-1:0]        rd_x,
  output logic [YW-1:0]        rd_y,
  input  logic [BUS_WIDTH-1:0] rd_value,
  board_scanner_if.master      scan_out,
  output logic                 frame_done
);

  scan_state_t   state;
  scan_state_t   next_state;
  logic          cursor_clear;
  logic          cursor_advance;
  logic          load_cell;
  logic          drop_valid;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          cur_first;
  logic          cur_last;

  board_cursor #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .clear    (cursor_clear),
    .advance  (cursor_advance),
    .x        (cur_x),
    .y        (cur_y),
    .is_first (cur_first),
    .is_last  (cur_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and cursor/output-register control. Abort is folded in last so
  // it overrides whatever the current state wanted, including a read in flight.
  always_comb begin
    next_state     = state;
    cursor_clear   = 1'b0;
    cursor_advance = 1'b0;
    load_cell      = 1'b0;
    drop_valid     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state   = FETCH;
          cursor_clear = 1'b1;
        end
      end
      FETCH: begin
        next_state = CAPTURE;
      end
      CAPTURE: begin
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
        if (rd_value == '0) begin
          if (cur_last) begin
            next_state = DONE;
          end else begin
            cursor_advance = 1'b1;
            next_state     = FETCH;
          end
        end else begin
          load_cell  = 1'b1;
          next_state = PRESENT;
        end
`else
        load_cell  = 1'b1;
        next_state = PRESENT;
`endif
      end
      PRESENT: begin
        if (scan_out.out_ready) begin
          drop_valid = 1'b1;
          if (cur_last) begin
            next_state = DONE;
          end else begin
            cursor_advance = 1'b1;
            next_state     = FETCH;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (abort && (state != IDLE)) begin
      next_state     = IDLE;
      cursor_clear   = 1'b1;
      cursor_advance = 1'b0;
      load_cell      = 1'b0;
      drop_valid     = 1'b1;
    end
  end

  // Presented-cell registers. They only change on a load, so the cell stays
  // frozen for as long as the consumer holds off ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_out.out_valid <= 1'b0;
      scan_out.out_x     <= '0;
      scan_out.out_y     <= '0;
      scan_out.out_value <= '0;
      scan_out.out_first <= 1'b0;
      scan_out.out_last  <= 1'b0;
    end else if (load_cell) begin
      scan_out.out_valid <= 1'b1;
      scan_out.out_x     <= cur_x;
      scan_out.out_y     <= cur_y;
      scan_out.out_value <= rd_value;
      scan_out.out_first <= cur_first;
      scan_out.out_last  <= cur_last;
    end else if (drop_valid) begin
      scan_out.out_valid <= 1'b0;
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign rd_en      = (state == FETCH);
  assign rd_x       = (state == FETCH) ? cur_x : '0;
  assign rd_y       = (state == FETCH) ? cur_y : '0;

endmodule

// File: tb/tb_board_scanner.sv
// -----------------------------------------------------------------------------
// tb_board_scanner
// Directed bench for board_scanner on a 4x3 board. A small board memory with
// one-cycle read latency answers the read port; expected cells come from
// hand-written tables that also carry per-cell backpressure lengths.
// -----------------------------------------------------------------------------
module tb_board_scanner;
  import board_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          rd_en;
  logic [1:0]    rd_x;
  logic [1:0]    rd_y;
  logic [BW-1:0] rd_value = '0;
  logic          frame_done;

  board_scanner_if #(.WIDTH(W), .HEIGHT(H), .BUS_WIDTH(BW)) scan_out ();

  board_scanner #(.WIDTH(W), .HEIGHT(H), .BUS_WIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_value   (rd_value),
    .scan_out   (scan_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Board store model: data appears the cycle after the read strobe.
  logic [BW-1:0] board [W*H];
  always @(posedge clk) begin
    if (rd_en) rd_value <= board[int'(rd_y) * W + int'(rd_x)];
  end

  typedef struct {
    int stall;
    int x;
    int y;
    int value;
    int first;
    int last;
  } vec_t;

  vec_t vecs [W*H];
  int   nExp;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " rd_en"}, rd_en, 0);
    checkOutput({tag, " rd_x/rd_y"}, {rd_y, rd_x}, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " out_valid"}, scan_out.out_valid, 0);
    checkOutput({tag, " out_x/out_y/out_value"},
                {scan_out.out_x, scan_out.out_y, scan_out.out_value}, 0);
    checkOutput({tag, " out_first/out_last"}, {scan_out.out_first, scan_out.out_last}, 0);
  endtask

  // Starts one frame from a negedge and consumes it against vecs[0..nExp-1].
  // Cycle numbers count negedges after the start request, so the first cell
  // must be visible at cycle 3 (FETCH, CAPTURE, then registered out_valid).
  task automatic applyStimulus(input bit checkLatency, input bit extraStart);
    int idx, cyc, stallLeft, doneCount, doneCyc, lastAcceptCyc, firstValidCyc, extras;
    idx = 0; cyc = 0; doneCount = 0; doneCyc = -1; lastAcceptCyc = -100;
    firstValidCyc = -1; extras = 0;
    stallLeft = vecs[0].stall;
    scan_out.out_ready = 1'b1;
    start = 1'b1;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = extraStart && (cyc >= 4) && (cyc <= 12);
      if (checkLatency && cyc == 1) begin
        checkOutput("rd_en in first FETCH", rd_en, 1);
        checkOutput("rd_x/rd_y in first FETCH", {rd_y, rd_x}, 0);
      end
      if (frame_done) begin
        doneCount++;
        doneCyc = cyc;
        checkOutput("frame_done cycles after last accept", cyc - lastAcceptCyc, 1);
      end
      if (scan_out.out_valid) begin
        if (firstValidCyc < 0) firstValidCyc = cyc;
        if (idx >= nExp) begin
          extras++;
          lastAcceptCyc = cyc;
          scan_out.out_ready = 1'b1;
        end else begin
          checkOutput($sformatf("cell %0d out_x", idx), scan_out.out_x, vecs[idx].x);
          checkOutput($sformatf("cell %0d out_y", idx), scan_out.out_y, vecs[idx].y);
          checkOutput($sformatf("cell %0d out_value", idx), scan_out.out_value, vecs[idx].value);
          checkOutput($sformatf("cell %0d out_first", idx), scan_out.out_first, vecs[idx].first);
          checkOutput($sformatf("cell %0d out_last", idx), scan_out.out_last, vecs[idx].last);
          if (stallLeft > 0) begin
            checkOutput($sformatf("cell %0d rd_en while stalled", idx), rd_en, 0);
            scan_out.out_ready = 1'b0;
            stallLeft--;
          end else begin
            scan_out.out_ready = 1'b1;
            idx++;
            lastAcceptCyc = cyc;
            stallLeft = (idx < nExp) ? vecs[idx].stall : 0;
          end
        end
      end else begin
        scan_out.out_ready = 1'b1;
      end
      if (doneCount > 0 && cyc >= doneCyc + 4) break;
    end
    start = 1'b0;
    scan_out.out_ready = 1'b1;
    checkOutput("frame completed within budget", int'(doneCount > 0), 1);
    checkOutput("cells accepted", idx + extras, nExp);
    checkOutput("frame_done pulses", doneCount, 1);
    if (checkLatency) checkOutput("first out_valid cycle", firstValidCyc, 3);
    checkOutput("busy after frame", busy, 0);
  endtask

  // Runs a frame with out_ready high until the cell (tx,ty) is presented,
  // then leaves it presented with out_ready low. Returns whether it was found.
  task automatic runUntilCell(input int tx, input int ty, output bit found);
    found = 1'b0;
    scan_out.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (scan_out.out_valid && scan_out.out_x == 2'(tx) && scan_out.out_y == 2'(ty)) begin
        scan_out.out_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic loadMainTable();
    vecs[0]  = '{0, 0, 0,  0, 1, 0};
    vecs[1]  = '{0, 1, 0,  1, 0, 0};
    vecs[2]  = '{0, 2, 0,  2, 0, 0};
    vecs[3]  = '{0, 3, 0,  3, 0, 0};
    vecs[4]  = '{0, 0, 1,  4, 0, 0};
    vecs[5]  = '{0, 1, 1,  5, 0, 0};
    vecs[6]  = '{0, 2, 1,  6, 0, 0};
    vecs[7]  = '{0, 3, 1,  7, 0, 0};
    vecs[8]  = '{0, 0, 2,  8, 0, 0};
    vecs[9]  = '{0, 1, 2,  9, 0, 0};
    vecs[10] = '{0, 2, 2, 10, 0, 0};
    vecs[11] = '{0, 3, 2, 11, 0, 1};
    nExp = 12;
  endtask

  initial begin
    bit found;
    scan_out.out_ready = 1'b1;
    for (int i = 0; i < W*H; i++) board[i] = BW'(i);

    // Reset state, while held and after release
    repeat (2) @(negedge clk);
    checkIdle("in reset");
    reset = 1'b1;
    @(negedge clk);
    checkIdle("after reset release");

    // Full frame with the consumer always ready
    loadMainTable();
    applyStimulus(1'b1, 1'b0);

    // Five cycles of backpressure on cell (2,1)
    vecs[6].stall = 5;
    applyStimulus(1'b1, 1'b0);
    vecs[6].stall = 0;

    // Abort while (1,2) is presented, then a clean rescan
    runUntilCell(1, 2, found);
    checkOutput("reached cell (1,2) before abort", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort out_valid", scan_out.out_valid, 0);
    checkOutput("abort rd_en", rd_en, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort no frame_done", frame_done, 0);
      @(negedge clk);
    end
    scan_out.out_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);

    // Asynchronous reset in the middle of presenting (1,1)
    runUntilCell(1, 1, found);
    checkOutput("reached cell (1,1) before reset", found, 1);
    #2 reset = 1'b0;
    #1 checkIdle("async reset mid-frame");
    @(negedge clk);
    reset = 1'b1;
    scan_out.out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);

    // start pulses while busy must not restart or chain a second frame
    applyStimulus(1'b1, 1'b1);

    // start together with abort in idle: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start+abort busy", busy, 0);
    @(negedge clk);
    checkOutput("start+abort rd_en", rd_en, 0);
    checkOutput("start+abort frame_done", frame_done, 0);

    // Sparse board: only (1,0)=5 and (3,2)=7 are nonzero
    for (int i = 0; i < W*H; i++) board[i] = '0;
    board[1]  = 4'd5;
    board[11] = 4'd7;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
    vecs[0] = '{0, 1, 0, 5, 0, 0};
    vecs[1] = '{0, 3, 2, 7, 0, 1};
    nExp = 2;
    applyStimulus(1'b0, 1'b0);
`else
    loadMainTable();
    for (int i = 0; i < W*H; i++) vecs[i].value = 0;
    vecs[1].value  = 5;
    vecs[11].value = 7;
    applyStimulus(1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
